// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the instruction cache and its neighbours.
package lc3b_types;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned SEL_W  = 16;

    typedef logic [LINE_W-1:0] lc3b_line;
    typedef logic [15:0]       lc3b_word;
    typedef logic [ADDR_W-1:0] lc3b_addr;

    typedef enum logic {
        IDLE,
        FILL
    } lc3b_icache_state;

endpackage

// File: rtl/wishbone.sv
// Wishbone bus bundle: 12-bit line address, 128-bit data in both directions.
interface wishbone;
    import lc3b_types::*;

    lc3b_addr           ADR;
    lc3b_line           DAT_M;
    lc3b_line           DAT_S;
    logic [SEL_W-1:0]   SEL;
    logic               CYC;
    logic               STB;
    logic               WE;
    logic               ACK;

    modport master (
        output ADR, DAT_M, SEL, CYC, STB, WE,
        input  DAT_S, ACK
    );

    modport slave (
        input  ADR, DAT_M, SEL, CYC, STB, WE,
        output DAT_S, ACK
    );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid/tag/data with one write port and async read.
module icache_array
    import lc3b_types::*;
#(
    parameter int unsigned SETS  = 8,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = ADDR_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  lc3b_line         wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output lc3b_line         rdata
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    lc3b_line         data_q [SETS];

    // A clear in the same cycle as a write wins, so a flushed fill stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped L1 instruction cache with zero-latency hits and single-beat line refill.
module l1_icache
    import lc3b_types::*;
#(
    parameter int unsigned SETS = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    wishbone.slave   cpu,
    wishbone.master  mem,
    input  logic     flush
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    lc3b_icache_state state_q, state_d;
    lc3b_addr         fill_addr_q;

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    lc3b_line         line_data;
    logic             req;
    logic             hit;
    logic             miss;
    logic             fill_done;

    assign lookup_idx = cpu.ADR[IDX_W-1:0];
    assign lookup_tag = cpu.ADR[ADDR_W-1:IDX_W];

    assign req  = cpu.CYC & cpu.STB;
    assign hit  = (state_q == IDLE) & req & line_valid & (line_tag == lookup_tag) & ~flush;
    assign miss = (state_q == IDLE) & req & ~hit & ~flush;
    assign fill_done = (state_q == FILL) & mem.ACK;

    // Writes never store anything; these inputs exist only for bus compatibility.
    logic unused_cpu;
    assign unused_cpu = ^{cpu.WE, cpu.DAT_M, cpu.SEL};

    icache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (flush),
        .we     (fill_done),
        .widx   (fill_addr_q[IDX_W-1:0]),
        .wtag   (fill_addr_q[ADDR_W-1:IDX_W]),
        .wdata  (mem.DAT_S),
        .ridx   (lookup_idx),
        .rvalid (line_valid),
        .rtag   (line_tag),
        .rdata  (line_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The fill address is frozen for the whole refill regardless of cpu.ADR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_addr_q <= '0;
        end else if (miss) begin
            fill_addr_q <= cpu.ADR;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (miss)    state_d = FILL;
            FILL: if (mem.ACK) state_d = IDLE;
        endcase
    end

    always_comb begin
        mem.CYC   = 1'b0;
        mem.STB   = 1'b0;
        mem.WE    = 1'b0;
        mem.SEL   = '0;
        mem.DAT_M = '0;
        mem.ADR   = fill_addr_q;
        cpu.ACK   = hit;
        cpu.DAT_S = hit ? line_data : '0;
        if (state_q == FILL) begin
            mem.CYC = 1'b1;
            mem.STB = 1'b1;
            mem.SEL = '1;
        end
    end

endmodule

// File: tb/tb_l1_icache.sv
// Scoreboard bench for l1_icache: directed accesses, queued expectations, bus monitors.
module tb_l1_icache;
    import lc3b_types::*;

    logic clk;
    logic rst_n;
    logic flush;
    logic force_ack;
    int   mem_cnt;

    int n_checks;
    int n_fail;
    int ack_cnt;

    lc3b_line data_q[$];
    lc3b_addr fill_q[$];
    lc3b_addr cur_fill;
    logic     prev_cyc;

    localparam lc3b_line D010 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam lc3b_line D018 = 128'hA018A018A018A018A018A018A018A018;
    localparam lc3b_line D020 = 128'hA020A020A020A020A020A020A020A020;
    localparam lc3b_line D031 = 128'hA031A031A031A031A031A031A031A031;
    localparam lc3b_line D040 = 128'hA040A040A040A040A040A040A040A040;
    localparam lc3b_line D050 = 128'hA050A050A050A050A050A050A050A050;
    localparam lc3b_line D058 = 128'hA058A058A058A058A058A058A058A058;
    localparam lc3b_line D060 = 128'hA060A060A060A060A060A060A060A060;

    wishbone cpu_bus ();
    wishbone mem_bus ();

    l1_icache #(
        .SETS (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu_bus),
        .mem   (mem_bus),
        .flush (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic lc3b_line mem_data(input lc3b_addr a);
        if (a == 12'h010) return D010;
        return {8{4'hA, a}};
    endfunction

    // Memory answers on the third cycle of each bus cycle.
    assign mem_bus.ACK   = (mem_bus.CYC && mem_bus.STB && mem_cnt == 2) || force_ack;
    assign mem_bus.DAT_S = mem_data(mem_bus.ADR);

    always @(posedge clk) begin
        if (mem_bus.CYC && mem_bus.STB && !mem_bus.ACK) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // CPU-side monitor: every ACK must match the oldest queued expectation.
    always @(negedge clk) begin
        if (cpu_bus.ACK) begin
            if (data_q.size() == 0) fail_now("unexpected_cpu_ack");
            else chk("cpu_dat", cpu_bus.DAT_S, data_q.pop_front());
            ack_cnt++;
        end else begin
            chk("dat_zero_noack", cpu_bus.DAT_S, '0);
        end
    end

    // Memory-side monitor: each new bus cycle must be an expected refill, held stable.
    always @(negedge clk) begin
        if (mem_bus.CYC) begin
            if (!prev_cyc) begin
                if (fill_q.size() == 0) fail_now("unexpected_fill");
                else cur_fill = fill_q.pop_front();
            end
            chk("fill_adr", 128'(mem_bus.ADR), 128'(cur_fill));
            chk("fill_stb", 128'(mem_bus.STB), 128'd1);
            chk("fill_we", 128'(mem_bus.WE), 128'd0);
            chk("fill_sel", 128'(mem_bus.SEL), 128'hFFFF);
            chk("fill_datm", mem_bus.DAT_M, '0);
        end else begin
            chk("idle_stb", 128'(mem_bus.STB), 128'd0);
            chk("idle_we", 128'(mem_bus.WE), 128'd0);
        end
        prev_cyc = mem_bus.CYC;
    end

    // Called just after a rising edge; returns just after the edge that follows the ACK.
    task automatic access(input lc3b_addr addr, input lc3b_line exp_data, input int exp_lat,
                          input int chg_at, input lc3b_addr chg_addr, input int flush_at,
                          input logic we);
        int cycles;
        int start;
        data_q.push_back(exp_data);
        cpu_bus.ADR   = addr;
        cpu_bus.WE    = we;
        cpu_bus.DAT_M = {8{16'hDEAD}};
        cpu_bus.SEL   = '0;
        cpu_bus.CYC   = 1'b1;
        cpu_bus.STB   = 1'b1;
        flush = (flush_at == 0);
        cycles = 0;
        start = ack_cnt;
        while (ack_cnt == start && cycles < 40) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == chg_at) cpu_bus.ADR = chg_addr;
            flush = (cycles == flush_at);
        end
        flush = 1'b0;
        cpu_bus.CYC = 1'b0;
        cpu_bus.STB = 1'b0;
        cpu_bus.WE  = 1'b0;
        chk("latency", 128'(cycles), 128'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        ack_cnt = 0;
        prev_cyc = 1'b0;
        cur_fill = '0;
        force_ack = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        cpu_bus.ADR = '0;
        cpu_bus.DAT_M = '0;
        cpu_bus.SEL = '0;
        cpu_bus.CYC = 1'b0;
        cpu_bus.STB = 1'b0;
        cpu_bus.WE = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_cyc", 128'(mem_bus.CYC), 128'd0);
        chk("reset_cpu_ack", 128'(cpu_bus.ACK), 128'd0);
        rst_n = 1'b1;

        // Cold miss, hit, conflict eviction.
        fill_q.push_back(12'h010);
        access(12'h010, D010, 5, -1, '0, -1, 1'b0);
        access(12'h010, D010, 1, -1, '0, -1, 1'b0);
        fill_q.push_back(12'h018);
        access(12'h018, D018, 5, -1, '0, -1, 1'b0);
        fill_q.push_back(12'h010);
        access(12'h010, D010, 5, -1, '0, -1, 1'b0);

        // Address change mid-fill: 020 still fills, then 031 is looked up afresh.
        fill_q.push_back(12'h020);
        fill_q.push_back(12'h031);
        access(12'h020, D031, 9, 2, 12'h031, -1, 1'b0);
        access(12'h020, D020, 1, -1, '0, -1, 1'b0);
        access(12'h031, D031, 1, -1, '0, -1, 1'b0);

        // Flush on the memory ACK cycle leaves the line invalid and forces a refetch.
        fill_q.push_back(12'h040);
        fill_q.push_back(12'h040);
        access(12'h040, D040, 9, -1, '0, 3, 1'b0);

        // Flush with the request in IDLE suppresses the hit.
        fill_q.push_back(12'h040);
        access(12'h040, D040, 6, -1, '0, 0, 1'b0);

        // WE=1 behaves as a read.
        access(12'h040, D040, 1, -1, '0, -1, 1'b1);

        // Flush during a fill without ACK does not abort it; line lands valid.
        fill_q.push_back(12'h058);
        access(12'h058, D058, 5, -1, '0, 2, 1'b0);
        access(12'h058, D058, 1, -1, '0, -1, 1'b0);

        // CPU drops the request mid-fill; fill still completes.
        fill_q.push_back(12'h060);
        cpu_bus.ADR = 12'h060;
        cpu_bus.CYC = 1'b1;
        cpu_bus.STB = 1'b1;
        @(posedge clk);
        #1;
        cpu_bus.CYC = 1'b0;
        cpu_bus.STB = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        access(12'h060, D060, 1, -1, '0, -1, 1'b0);

        // Reset mid-fill, then a stray memory ACK.
        fill_q.push_back(12'h050);
        cpu_bus.ADR = 12'h050;
        cpu_bus.CYC = 1'b1;
        cpu_bus.STB = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        cpu_bus.CYC = 1'b0;
        cpu_bus.STB = 1'b0;
        #1;
        chk("reset_abort_cyc", 128'(mem_bus.CYC), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("late_ack_ignored", 128'(mem_bus.CYC), 128'd0);
        fill_q.push_back(12'h050);
        access(12'h050, D050, 5, -1, '0, -1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("data_q_empty", 128'(data_q.size()), 128'd0);
        chk("fill_q_empty", 128'(fill_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
